lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the execute stage and the DPI-backed physical memory port. Memory port signals: raddr, waddr, wdata, wmask, write enable, rdata with same-cycle combinational read.
- Accepts one load or store per request handshake.
- Generates the 8-byte-aligned beat address, byte mask and shifted write data.
- Splits accesses that cross an 8-byte boundary into two beats.
- Reassembles and sign/zero-extends load data.
- Returns a single response to the pipeline.

Parameters:
- RESET_ADDR, 64'h0000_0000_8000_0000: value of mem_raddr/mem_waddr whenever no beat is active; always a legal pmem address.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_wen  input  1  1 = store, 0 = load
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-aligned
- req_size  input  2  0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- resp_valid  output  1  response present
- resp_ready  input  1  pipeline accepts the response
- resp_rdata  output  64  extended load data; 0 for stores
- resp_err  output  1  misalignment error (see Optional Feature)
- mem_raddr  output  64  beat read address, low 3 bits always 0
- mem_waddr  output  64  beat write address, low 3 bits always 0
- mem_wdata  output  64  beat write data, byte-lane positioned
- mem_wmask  output  8  beat byte mask
- mem_wen  output  1  beat write strobe
- mem_rdata  input  64  read data for mem_raddr, valid in the same cycle

Behaviour:
- Reset: state IDLE. req_ready=0 while rst=1. resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_wmask=0, mem_wdata=0, mem_raddr=mem_waddr=RESET_ADDR.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register addr, size, wen, wdata and unsigned, then go to BEAT0.
- Beat computation:
  - off = addr[2:0]; nbytes = 1<<size.
  - m16 = ((1<<nbytes)-1) << off, 16 bits.
  - d128 = {64'b0, wdata} << (8*off).
  - split = |m16[15:8].
- BEAT0:
  - mem_raddr = mem_waddr = {addr[63:3],3'b0}; mem_wmask = m16[7:0]; mem_wdata = d128[63:0].
  - mem_wen = wen, asserted for exactly this one cycle.
  - Register mem_rdata into lo buffer at the cycle end.
  - Next state: BEAT1 if split, else RESP.
- BEAT1:
  - Address is the BEAT0 address + 8, wrapping modulo 2^64; mem_wmask = m16[15:8]; mem_wdata = d128[127:64].
  - mem_wen = wen for one cycle.
  - Register mem_rdata into hi buffer (hi=0 when unsplit). Next state RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_ready.
  - Load data: r = ({hi,lo} >> 8*off)[8*nbytes-1:0], extended to 64 bits per req_unsigned. Size 3 ignores req_unsigned.
  - Store: resp_rdata=0.
  - On resp_ready, go to IDLE.
  - A new request cannot be accepted in the same cycle as the response; req_ready=0 in RESP.
- Idle port values: outside BEAT0/BEAT1, mem_wen=0, mem_wmask=0, and addresses=RESET_ADDR.
- Latency from acceptance at edge N: resp_valid at N+2 unsplit, N+3 split.
- Outputs depend on registered state only; there is no combinational path from req_* or resp_ready to mem_*.
- Reset mid-operation: next edge returns to IDLE and mem_wen drops. A split store reset between the beats leaves beat0 written; this is accepted.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined: when addr is not a multiple of nbytes, go IDLE→RESP directly. No beat is issued and mem_wen stays 0. RESP has resp_err=1 and resp_rdata=0. Aligned accesses behave as normal with resp_err=0.
- Undefined: resp_err is tied to 0 and misaligned accesses are split as described above.

Test Plan:
- Aligned 8B load at 0x80000008, memory returns 0x1122334455667788 → one beat with mem_raddr=0x80000008, mem_wen=0; resp_rdata=0x1122334455667788 at N+2.
- 1B store of 0xAB at 0x80000003 → mem_waddr=0x80000000, mem_wmask=0x08, mem_wdata[31:24]=0xAB, mem_wen high for exactly 1 cycle.
- Signed 2B load at 0x80000006, memory holds 0x8001 at bytes 6..7 → resp_rdata=0xFFFFFFFFFFFF8001; with req_unsigned=1 → 0x0000000000008001.
- Split 4B store of 0xDEADBEEF at 0x80000006, macro undefined:
  - beat0: mask 0xC0, wdata[63:48]=0xBEEF, addr 0x80000000.
  - beat1: mask 0x03, wdata[15:0]=0xDEAD, addr 0x80000008.
  - resp_valid at N+3.
- Same split access with LSU_ALIGN_CHECK_EN defined → no mem_wen pulse, resp_err=1 at N+1, resp_rdata=0.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable, req_ready=0. Assert rst during BEAT1 of a split store → IDLE next edge, mem_wen=0, resp_valid never asserted.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator that splits, positions and reassembles accesses for a
// same-cycle-read memory port. Define LSU_ALIGN_CHECK_EN to trap misaligned accesses with resp_err.
module lsu_mem_master #(
  parameter logic [63:0] RESET_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_wen,
  input  logic [63:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]   state_r, state_s;
  logic [2:0]   off_r;
  logic [1:0]   size_r;
  logic         wen_r, uns_r, err_r, split_r;
  logic [7:0]   pend_mask_r;
  logic [63:0]  pend_data_r, lo_r, hi_r;
  logic         resp_valid_r, resp_err_r;
  logic [63:0]  resp_rdata_r;
  logic [63:0]  mem_addr_r, mem_addr_s, mem_wdata_r, mem_wdata_s;
  logic [7:0]   mem_wmask_r, mem_wmask_s;
  logic         mem_wen_r, mem_wen_s;
  logic         accept_s, misaligned_s;
  logic [15:0]  acc_mask_s;
  logic [127:0] acc_data_s;
  logic [63:0]  load_s;

  function automatic logic [15:0] beat_mask(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    beat_mask = {8'h00, base} << off;
  endfunction

  function automatic logic [127:0] beat_data(input logic [2:0] off, input logic [63:0] wdata);
    beat_data = {64'h0, wdata} << {off, 3'b000};
  endfunction

  function automatic logic [63:0] load_extend(input logic [127:0] raw, input logic [2:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = 64'(raw >> {off, 3'b000});
    case (size)
      2'd0:    load_extend = uns ? {56'h0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    load_extend = uns ? {48'h0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    load_extend = uns ? {32'h0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: load_extend = sh;
    endcase
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction
  assign misaligned_s = is_misaligned(req_addr[2:0], req_size);
`else
  assign misaligned_s = 1'b0;
`endif

  assign accept_s   = req_valid && (state_r == IDLE);
  assign acc_mask_s = beat_mask(req_addr[2:0], req_size);
  assign acc_data_s = beat_data(req_addr[2:0], req_wdata);
  assign load_s     = load_extend({hi_r, lo_r}, off_r, size_r, uns_r);

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = misaligned_s ? RESP : BEAT0;
        end else begin
          state_s = IDLE;
        end
      end
      BEAT0:   state_s = split_r ? BEAT1 : RESP;
      BEAT1:   state_s = RESP;
      RESP: begin
        if (resp_valid_r && resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Memory port values for the cycle that follows this edge; the port is parked otherwise.
  always_comb begin
    mem_addr_s  = RESET_ADDR;
    mem_wdata_s = 64'h0;
    mem_wmask_s = 8'h00;
    mem_wen_s   = 1'b0;
    if (state_s == BEAT0) begin
      mem_addr_s  = {req_addr[63:3], 3'b000};
      mem_wdata_s = acc_data_s[63:0];
      mem_wmask_s = acc_mask_s[7:0];
      mem_wen_s   = req_wen;
    end else if (state_s == BEAT1) begin
      mem_addr_s  = mem_addr_r + 64'd8;
      mem_wdata_s = pend_data_r;
      mem_wmask_s = pend_mask_r;
      mem_wen_s   = wen_r;
    end else begin
      mem_addr_s  = RESET_ADDR;
      mem_wdata_s = 64'h0;
      mem_wmask_s = 8'h00;
      mem_wen_s   = 1'b0;
    end
  end

  // State, request capture, read buffers and the registered memory port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      off_r       <= 3'd0;
      size_r      <= 2'd0;
      wen_r       <= 1'b0;
      uns_r       <= 1'b0;
      err_r       <= 1'b0;
      split_r     <= 1'b0;
      pend_mask_r <= 8'h00;
      pend_data_r <= 64'h0;
      lo_r        <= 64'h0;
      hi_r        <= 64'h0;
      mem_addr_r  <= RESET_ADDR;
      mem_wdata_r <= 64'h0;
      mem_wmask_r <= 8'h00;
      mem_wen_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_wmask_r <= mem_wmask_s;
      mem_wen_r   <= mem_wen_s;
      if (accept_s) begin
        off_r       <= req_addr[2:0];
        size_r      <= req_size;
        wen_r       <= req_wen;
        uns_r       <= req_unsigned;
        err_r       <= misaligned_s;
        split_r     <= |acc_mask_s[15:8];
        pend_mask_r <= acc_mask_s[15:8];
        pend_data_r <= acc_data_s[127:64];
        lo_r        <= 64'h0;
        hi_r        <= 64'h0;
      end else if (state_r == BEAT0) begin
        lo_r <= mem_rdata;
      end else if (state_r == BEAT1) begin
        hi_r <= mem_rdata;
      end
    end
  end

  // Response register: formed on the first RESP cycle, then frozen until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'h0;
      resp_err_r   <= 1'b0;
    end else if (state_r == RESP) begin
      if (!resp_valid_r) begin
        resp_valid_r <= 1'b1;
        resp_rdata_r <= (wen_r || err_r) ? 64'h0 : load_s;
        resp_err_r   <= err_r;
      end else if (resp_ready) begin
        resp_valid_r <= 1'b0;
        resp_rdata_r <= 64'h0;
        resp_err_r   <= 1'b0;
      end
    end
  end

  assign req_ready  = (state_r == IDLE) && !rst;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_raddr  = mem_addr_r;
  assign mem_waddr  = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wmask  = mem_wmask_r;
  assign mem_wen    = mem_wen_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed and randomized checks of lsu_mem_master against a byte-array model.
module tb_lsu_mem_master;

  localparam logic [63:0] RESET_ADDR = 64'h0000_0000_8000_0000;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        mem_wen;

  int tests = 0;
  int fails = 0;

  logic [7:0]  dut_mem [128];
  logic [7:0]  ref_mem [128];
  logic        init_en, poke_en;
  int          poke_idx;
  logic [7:0]  poke_val;
  logic [63:0] rd_idx, wr_idx;

  logic [63:0] b_addr [2];
  logic [7:0]  b_mask [2];
  logic [63:0] b_data [2];
  logic [63:0] first_raddr;

  lsu_mem_master #(.RESET_ADDR(RESET_ADDR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    pat = 8'((i * 29 + 90) & 255);
  endfunction

  // 128-byte memory at RESET_ADDR, combinational read.
  always_comb begin
    mem_rdata = 64'h0;
    rd_idx = mem_raddr - RESET_ADDR;
    if (rd_idx < 64'd128) begin
      for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = dut_mem[int'(rd_idx[6:0]) + i];
    end
  end

  assign wr_idx = mem_waddr - RESET_ADDR;

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 128; i++) dut_mem[i] <= pat(i);
    end else if (poke_en) begin
      dut_mem[poke_idx] <= poke_val;
    end else if (mem_wen && wr_idx < 64'd128) begin
      for (int i = 0; i < 8; i++)
        if (mem_wmask[i]) dut_mem[int'(wr_idx[6:0]) + i] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [7:0] val);
    ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Reference load: gather bytes little-endian, then extend.
  function automatic logic [63:0] ref_load(input int off, input int n, input logic uns);
    logic [63:0] v;
    v = 64'h0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[off + i]) << (8 * i));
    if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'h1 << (8 * n)) - 64'h1);
    return v;
  endfunction

  task automatic run_req(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, input logic uns, input int hold,
                         output logic [63:0] rdata, output logic err, output int lat, output int nwen);
    int cyc;
    bit done;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_wdata = wdata; req_unsigned = uns;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; nwen = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (cyc == 0) first_raddr = mem_raddr;
      if (mem_wen && nwen < 2) begin
        b_addr[nwen] = mem_waddr; b_mask[nwen] = mem_wmask; b_data[nwen] = mem_wdata;
      end
      if (mem_wen) nwen++;
      if (resp_valid) begin
        lat = cyc;
        done = 1'b1;
      end
      cyc++;
    end
    rdata = resp_rdata;
    err = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, rdata);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] got;
    logic        gerr;
    int          lat, nw;

    rst = 1'b1; init_en = 1'b1; poke_en = 1'b0; poke_idx = 0; poke_val = 8'h00;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'h0; req_wdata = 64'h0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
    @(posedge clk);
    #1 init_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'h0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_mem_raddr", mem_raddr, RESET_ADDR);
    chk("rst_mem_waddr", mem_waddr, RESET_ADDR);
    rst = 1'b0;

    // Aligned 8-byte load.
    for (int i = 0; i < 8; i++) poke(8 + i, 8'(64'h1122334455667788 >> (8 * i)));
    run_req(1'b0, 64'h8000_0008, 2'd3, 64'h0, 1'b0, 0, got, gerr, lat, nw);
    chk("ld8_raddr", first_raddr, 64'h8000_0008);
    chk("ld8_nwen", 64'(nw), 64'd0);
    chk("ld8_rdata", got, 64'h1122334455667788);
    chk("ld8_lat", 64'(lat), 64'd2);

    // Byte store into lane 3.
    run_req(1'b1, 64'h8000_0003, 2'd0, 64'h0000_0000_0000_00AB, 1'b0, 0, got, gerr, lat, nw);
    ref_mem[3] = 8'hAB;
    chk("st1_nwen", 64'(nw), 64'd1);
    chk("st1_waddr", b_addr[0], 64'h8000_0000);
    chk("st1_wmask", 64'(b_mask[0]), 64'h08);
    chk("st1_lane", 64'(b_data[0][31:24]), 64'hAB);
    chk("st1_rdata", got, 64'h0);

    // Halfword load, signed then unsigned.
    poke(6, 8'h01);
    poke(7, 8'h80);
    run_req(1'b0, 64'h8000_0006, 2'd1, 64'h0, 1'b0, 0, got, gerr, lat, nw);
    chk("ld2s_rdata", got, 64'hFFFF_FFFF_FFFF_8001);
    run_req(1'b0, 64'h8000_0006, 2'd1, 64'h0, 1'b1, 0, got, gerr, lat, nw);
    chk("ld2u_rdata", got, 64'h0000_0000_0000_8001);

    // Word store straddling the 8-byte boundary.
    run_req(1'b1, 64'h8000_0006, 2'd2, 64'h0000_0000_DEAD_BEEF, 1'b0, 0, got, gerr, lat, nw);
`ifdef LSU_ALIGN_CHECK_EN
    chk("split_err_nwen", 64'(nw), 64'd0);
    chk("split_err_err", 64'(gerr), 64'd1);
    chk("split_err_lat", 64'(lat), 64'd1);
    chk("split_err_rdata", got, 64'h0);
`else
    for (int i = 0; i < 4; i++) ref_mem[6 + i] = 8'(64'hDEADBEEF >> (8 * i));
    chk("split_nwen", 64'(nw), 64'd2);
    chk("split_b0_addr", b_addr[0], 64'h8000_0000);
    chk("split_b0_mask", 64'(b_mask[0]), 64'hC0);
    chk("split_b0_data", 64'(b_data[0][63:48]), 64'hBEEF);
    chk("split_b1_addr", b_addr[1], 64'h8000_0008);
    chk("split_b1_mask", 64'(b_mask[1]), 64'h03);
    chk("split_b1_data", 64'(b_data[1][15:0]), 64'hDEAD);
    chk("split_lat", 64'(lat), 64'd3);
    chk("split_err", 64'(gerr), 64'd0);
`endif

    // Backpressure on a load response.
    run_req(1'b0, 64'h8000_0010, 2'd3, 64'h0, 1'b0, 5, got, gerr, lat, nw);
    chk("bp_rdata", got, ref_load(16, 8, 1'b0));

`ifndef LSU_ALIGN_CHECK_EN
    // Reset while the second beat of a split store is on the port.
    begin
      int seen;
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_002C; req_size = 2'd3;
      req_wdata = 64'h0102_0304_0506_0708; req_unsigned = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid_beat1_wen", 64'(mem_wen), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_wen", 64'(mem_wen), 64'd0);
      chk("rstmid_resp_valid", 64'(resp_valid), 64'd0);
      chk("rstmid_waddr", mem_waddr, RESET_ADDR);
      chk("rstmid_req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (resp_valid || mem_wen) seen++;
      end
      chk("rstmid_quiet", 64'(seen), 64'd0);
      for (int i = 0; i < 8; i++) ref_mem[44 + i] = 8'(64'h0102_0304_0506_0708 >> (8 * i));
    end
`endif

    // Randomized loads and stores against the byte model.
    for (int t = 0; t < 40; t++) begin
      int off, n, sub, el, ew;
      logic w, u, bad;
      logic [1:0] sz;
      logic [63:0] wd, er;
      off = $urandom_range(0, 119);
      sz = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      n = 1 << sz;
      sub = off % 8;
`ifdef LSU_ALIGN_CHECK_EN
      bad = ((off % n) != 0);
`else
      bad = 1'b0;
`endif
      el = bad ? 1 : ((sub + n > 8) ? 3 : 2);
      ew = (bad || !w) ? 0 : ((sub + n > 8) ? 2 : 1);
      er = (bad || w) ? 64'h0 : ref_load(off, n, u);
      run_req(w, RESET_ADDR + 64'(off), sz, wd, u, 0, got, gerr, lat, nw);
      chk("rnd_rdata", got, er);
      chk("rnd_err", 64'(gerr), 64'(bad));
      chk("rnd_lat", 64'(lat), 64'(el));
      chk("rnd_nwen", 64'(nw), 64'(ew));
      if (w && !bad) for (int i = 0; i < n; i++) ref_mem[off + i] = wd[8*i +: 8];
    end

    // Final memory image.
    for (int wi = 0; wi < 16; wi++) begin
      logic [63:0] dw, rw;
      for (int b = 0; b < 8; b++) begin
        dw[8*b +: 8] = dut_mem[8*wi + b];
        rw[8*b +: 8] = ref_mem[8*wi + b];
      end
      chk("mem_image", dw, rw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
